// File: rtl/onehot_scan_decoder_pkg.sv
// Purpose: shared types, mode constants and one-hot helper for the scan decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package onehot_scan_decoder_pkg;

   // Two-bit state encoding; ST_BLANK is only reachable when DECODER_BLANK_EN is defined.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIRECT = 2'd1,
      ST_SCAN   = 2'd2,
      ST_BLANK  = 2'd3
   } state_t;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Widest output the decoder supports (SEL_W <= 5).
   localparam int MAX_OUT_W = 32;

   // One-hot of idx within a w-bit field; zero when idx falls outside the field.
   function automatic logic [MAX_OUT_W-1:0] onehot(input logic [4:0] idx, input int unsigned w);
      logic [MAX_OUT_W-1:0] r;
      r = '0;
      if (32'(idx) < w) begin
         r[idx] = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/onehot_scan_decoder_if.sv
// Purpose: control inputs and decoded outputs of the scan decoder as one bundle.
// Latency: n/a (wires only).
// Backpressure: none; the decoder samples every input on every edge.
interface onehot_scan_decoder_if #(
   parameter int SEL_W = 3
);
   localparam int OUT_W = 2**SEL_W;

   logic             e;
   logic             mode;
   logic [SEL_W-1:0] a;
   logic             load;
   logic [OUT_W-1:0] mask;
   logic [OUT_W-1:0] s;
   logic [SEL_W-1:0] idx;
   logic             wrap;

   // Master drives controls and observes the decoded outputs.
   modport master (
      output e, mode, a, load, mask,
      input  s, idx, wrap
   );

   // Slave is the decoder itself.
   modport slave (
      input  e, mode, a, load, mask,
      output s, idx, wrap
   );

endinterface

// File: rtl/onehot_scan_decoder_next_chan.sv
// Purpose: finds the next enabled channel strictly after idx, searching upward modulo OUT_W.
// Latency: combinational.
// Backpressure: none.
module next_chan_find #(
   parameter int OUT_W = 8
) (
   input  logic [OUT_W-1:0]         mask,
   input  logic [$clog2(OUT_W)-1:0] idx,
   output logic [$clog2(OUT_W)-1:0] next_idx,
   output logic                     wrap,
   output logic                     none
);
   localparam int SEL_W = $clog2(OUT_W);

   logic             found;
   logic [SEL_W-1:0] cand;

   // Scan offsets 1..OUT_W; offset OUT_W lands back on idx, so a lone enabled channel re-selects itself.
   always_comb begin
      next_idx = idx;
      found    = 1'b0;
      cand     = idx;
      for (int k = 1; k <= OUT_W; k++) begin
         cand = idx + SEL_W'(k);
         if (!found && mask[cand]) begin
            next_idx = cand;
            found    = 1'b1;
         end
      end
      wrap = found && (next_idx <= idx);
      none = ~|mask;
   end

endmodule

// File: rtl/onehot_scan_decoder.sv
// Purpose: registered SEL_W-to-2^SEL_W one-hot decoder, direct or autonomous masked scan; optional DECODER_BLANK_EN inserts blank gaps.
// Latency: one edge from any input change to s/idx/wrap.
// Backpressure: none; inputs are sampled every edge, priority e=0 > direct > load > dwell expiry.
module onehot_scan_decoder
   import onehot_scan_decoder_pkg::*;
#(
   parameter int SEL_W = 3,
   parameter int DWELL = 4,
   parameter int BLANK = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   onehot_scan_decoder_if.slave      bus
);
   localparam int OUT_W   = 2**SEL_W;
   localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
`ifdef DECODER_BLANK_EN
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
`endif

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [OUT_W-1:0] s_q;
   logic [SEL_W-1:0] idx_q;
   logic             wrap_q;

   logic [SEL_W-1:0] nxt_idx;
   logic             nxt_wrap;
   logic             mask_none;

   // One-hot of a channel, suppressed when that channel is masked off.
   function automatic logic [OUT_W-1:0] gated(input logic [SEL_W-1:0] ch, input logic [OUT_W-1:0] mk);
      logic [OUT_W-1:0] r;
      r = '0;
      if (mk[ch]) begin
         r = OUT_W'(onehot(5'(ch), OUT_W));
      end
      return r;
   endfunction

   next_chan_find #(.OUT_W(OUT_W)) u_find (
      .mask     (bus.mask),
      .idx      (idx_q),
      .next_idx (nxt_idx),
      .wrap     (nxt_wrap),
      .none     (mask_none)
   );

   // Mode FSM with dwell counter; every output is a register updated here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         s_q    <= '0;
         idx_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         if (!bus.e) begin
            state <= ST_IDLE;
            cnt   <= '0;
            s_q   <= '0;
         end else if (bus.mode == MODE_DIRECT) begin
            state <= ST_DIRECT;
            cnt   <= '0;
            idx_q <= bus.a;
            s_q   <= gated(bus.a, bus.mask);
         end else if (bus.load) begin
            // Jump also aborts a blank gap; a masked target simply shows zero for one dwell.
            state <= ST_SCAN;
            cnt   <= '0;
            idx_q <= bus.a;
            s_q   <= gated(bus.a, bus.mask);
         end else if (state == ST_IDLE || state == ST_DIRECT) begin
            state <= ST_SCAN;
            cnt   <= '0;
            s_q   <= gated(idx_q, bus.mask);
         end else if (mask_none) begin
            // Nothing enabled: freeze position and count until a channel comes back.
            s_q <= '0;
         end else begin
`ifdef DECODER_BLANK_EN
            if (state == ST_BLANK) begin
               s_q <= '0;
               if (cnt == BLANK_LAST) begin
                  state  <= ST_SCAN;
                  cnt    <= '0;
                  idx_q  <= nxt_idx;
                  s_q    <= gated(nxt_idx, bus.mask);
                  wrap_q <= nxt_wrap;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end else if (cnt == DWELL_LAST) begin
               state <= ST_BLANK;
               cnt   <= '0;
               s_q   <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
               s_q <= gated(idx_q, bus.mask);
            end
`else
            if (cnt == DWELL_LAST) begin
               cnt    <= '0;
               idx_q  <= nxt_idx;
               s_q    <= gated(nxt_idx, bus.mask);
               wrap_q <= nxt_wrap;
            end else begin
               cnt <= cnt + CNT_W'(1);
               s_q <= gated(idx_q, bus.mask);
            end
`endif
         end
      end
   end

   assign bus.s    = s_q;
   assign bus.idx  = idx_q;
   assign bus.wrap = wrap_q;

endmodule
